// File: rtl/hmc_rf_regfile_if.sv
// hmc_rf_regfile_if: register-file access bus between a requester and hmc_rf_regfile.
interface hmc_rf_regfile_if #(
    parameter int HMC_RF_WWIDTH = 64,
    parameter int HMC_RF_RWIDTH = 64,
    parameter int HMC_RF_AWIDTH = 4
);
    logic [HMC_RF_AWIDTH-1:0] rf_address;
    logic [HMC_RF_WWIDTH-1:0] rf_write_data;
    logic                     rf_read_en;
    logic                     rf_write_en;
    logic [HMC_RF_RWIDTH-1:0] rf_read_data;
    logic                     rf_access_complete;
    logic                     rf_invalid_address;

    modport master (
        output rf_address, rf_write_data, rf_read_en, rf_write_en,
        input  rf_read_data, rf_access_complete, rf_invalid_address
    );

    modport slave (
        input  rf_address, rf_write_data, rf_read_en, rf_write_en,
        output rf_read_data, rf_access_complete, rf_invalid_address
    );
endinterface

// File: rtl/hmc_rf_regfile.sv
// hmc_rf_regfile: control/status register file with a 3-state access FSM and a saturating event counter.
module hmc_rf_regfile #(
    parameter int HMC_RF_WWIDTH = 64,
    parameter int HMC_RF_RWIDTH = 64,
    parameter int HMC_RF_AWIDTH = 4
) (
    input  logic                     clk_hmc,
    input  logic                     res_hmc,
    hmc_rf_regfile_if.slave          rf,
    input  logic [HMC_RF_RWIDTH-1:0] status_in,
    input  logic                     event_pulse,
    output logic [HMC_RF_WWIDTH-1:0] control_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e                   state_q, state_d;
    logic [HMC_RF_AWIDTH-1:0] addr_q;
    logic [HMC_RF_WWIDTH-1:0] wdata_q, ctrl_q, ctrl_d, scr_q, scr_d;
    logic [HMC_RF_RWIDTH-1:0] rdata_q, rdata_d, cnt_q, cnt_d, rd_val;
    logic                     rd_q, wr_q, inv_q, inv_d;
    logic                     exec, bad, wr_ok, rd_ok, clr;

    always_comb begin
        state_d = state_q == IDLE ? ((rf.rf_read_en | rf.rf_write_en) ? ACCESS : IDLE)
                : state_q == ACCESS ? DONE : IDLE;
        exec    = state_q == ACCESS;
        bad     = addr_q > HMC_RF_AWIDTH'(4);
        inv_d   = exec ? ((rd_q & wr_q) | bad) : inv_q;
        wr_ok   = exec & wr_q & ~rd_q & ~bad;
        rd_ok   = exec & rd_q & ~wr_q & ~bad;
        clr     = wr_ok & (addr_q == HMC_RF_AWIDTH'(4));
        ctrl_d  = (wr_ok && addr_q == HMC_RF_AWIDTH'(0)) ? wdata_q : ctrl_q;
        scr_d   = (wr_ok && addr_q == HMC_RF_AWIDTH'(3)) ? wdata_q : scr_q;
        rd_val  = addr_q == HMC_RF_AWIDTH'(0) ? HMC_RF_RWIDTH'(ctrl_q)
                : addr_q == HMC_RF_AWIDTH'(1) ? status_in
                : addr_q == HMC_RF_AWIDTH'(2) ? cnt_q
                : addr_q == HMC_RF_AWIDTH'(3) ? HMC_RF_RWIDTH'(scr_q) : '0;
        rdata_d = rd_ok ? rd_val : rdata_q;
        // a clear write takes priority over a coincident event pulse
        cnt_d   = clr ? '0 : (event_pulse && !(&cnt_q)) ? cnt_q + HMC_RF_RWIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk_hmc or posedge res_hmc) begin
        if (res_hmc) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            inv_q   <= 1'b0;
            ctrl_q  <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                addr_q  <= rf.rf_address;
                wdata_q <= rf.rf_write_data;
                rd_q    <= rf.rf_read_en;
                wr_q    <= rf.rf_write_en;
            end
            inv_q   <= inv_d;
            ctrl_q  <= ctrl_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign rf.rf_access_complete = state_q == DONE;
    assign rf.rf_invalid_address = (state_q == DONE) & inv_q;
    assign rf.rf_read_data       = rdata_q;
    assign control_out           = ctrl_q;
endmodule

// File: doc/hmc_rf_regfile.md
HMC_RF_REGFILE -- requirements
Module: hmc_rf_regfile

Interface
REQ-001 SHALL have parameter HMC_RF_WWIDTH, default 64, width of write data and of the control register.
REQ-002 SHALL have parameter HMC_RF_RWIDTH, default 64, width of read data, status input and event counter.
REQ-003 SHALL have parameter HMC_RF_AWIDTH, default 4, register address width.
REQ-004 SHALL have port clk_hmc  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port res_hmc  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rf_address  input  HMC_RF_AWIDTH  register address.
REQ-007 SHALL have port rf_write_data  input  HMC_RF_WWIDTH  value to write.
REQ-008 SHALL have port rf_read_en  input  1  read request.
REQ-009 SHALL have port rf_write_en  input  1  write request.
REQ-010 SHALL have port rf_read_data  output  HMC_RF_RWIDTH  read value, valid while rf_access_complete=1.
REQ-011 SHALL have port rf_access_complete  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rf_invalid_address  output  1  error flag, qualified by rf_access_complete.
REQ-013 SHALL have port status_in  input  HMC_RF_RWIDTH  live controller status.
REQ-014 SHALL have port event_pulse  input  1  increments event counter when 1 in a cycle.
REQ-015 SHALL have port control_out  output  HMC_RF_WWIDTH  current control register value.

Function
REQ-016 Register map SHALL be: 0x0 CONTROL (RW), 0x1 STATUS (RO, returns status_in sampled at access), 0x2 EVENT_CNT (RO), 0x3 SCRATCH (RW, WWIDTH), 0x4 CNT_CLEAR (WO; any write zeroes EVENT_CNT, reads return 0); 0x5 and above invalid.
REQ-017 FSM SHALL have states IDLE, ACCESS, DONE; IDLE->ACCESS on an edge where rf_read_en|rf_write_en=1; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-018 rf_address, rf_write_data and both enables SHALL be captured at the IDLE->ACCESS edge; inputs in ACCESS and DONE are ignored.
REQ-019 The write or read SHALL execute at the ACCESS->DONE edge; rf_access_complete SHALL be 1 exactly while in DONE (latency 2 cycles from capture edge).
REQ-020 rf_read_data SHALL be registered at ACCESS->DONE and hold its value until the next completed read; writes leave rf_read_data unchanged.
REQ-021 Width mismatch: reads of WWIDTH registers SHALL be zero-extended or truncated to RWIDTH.
REQ-022 Write to RO address (0x1, 0x2) SHALL complete with rf_invalid_address=0 and no state change.
REQ-023 Access to address >=0x5 SHALL complete with rf_invalid_address=1, no register change, rf_read_data unchanged.
REQ-024 Captured rf_read_en=1 and rf_write_en=1 together SHALL complete with rf_invalid_address=1 and no register change.
REQ-025 rf_invalid_address SHALL be 0 whenever rf_access_complete=0.
REQ-026 EVENT_CNT SHALL increment by 1 each cycle event_pulse=1, saturating at all-ones (no wrap).
REQ-027 A CNT_CLEAR write and event_pulse in the same cycle SHALL leave EVENT_CNT=0 (clear wins).
REQ-028 A read of EVENT_CNT SHALL return the value before that edge's increment.
REQ-029 control_out SHALL equal CONTROL at all times; update visible the cycle after ACCESS->DONE.

Reset
REQ-030 While res_hmc=1: state IDLE; CONTROL, SCRATCH, EVENT_CNT, rf_read_data = 0; rf_access_complete=0; rf_invalid_address=0.
REQ-031 Reset asserted in ACCESS or DONE SHALL abort the access with no register update and no completion pulse.
REQ-032 First request SHALL be accepted on the first rising edge with res_hmc=0.

Verification
REQ-033 Write 0x3 <- 0xDEAD_BEEF, then read 0x3 -> complete 2 cycles after each capture, rf_read_data=0xDEAD_BEEF, invalid=0.
REQ-034 Read 0x7 -> one-cycle complete with invalid=1, rf_read_data retains prior value.
REQ-035 10 event_pulse cycles, read 0x2 -> 10; write 0x4 while event_pulse=1, read 0x2 -> 0.
REQ-036 read_en and write_en both 1 to 0x0 with data 0x5 -> invalid=1, control_out stays 0.
REQ-037 Write 0x0 <- 0x1, assert res_hmc during ACCESS -> no complete pulse, control_out=0 after reset.
REQ-038 Force EVENT_CNT near all-ones (RWIDTH=8 build, 300 pulses) -> read 0x2 returns 0xFF.
